// File: rtl/uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend
//
// Receive front end for the key-check logic. It converts the raw asynchronous
// serial pin into a stream of bytes in 8N1 format, least significant bit first.
// The stage synchronises the pin and looks for a falling edge while idle. Every
// bit, including the start and stop bits, is resolved by a 2-of-3 majority vote
// around the bit centre. A good frame produces a one-cycle byte_valid strobe. A
// frame whose stop bit votes low produces a one-cycle frame_err strobe instead,
// and that byte is discarded.
//
// Parameters
//   CLKS_PER_BAUD  clk_10 cycles per bit (>= 8); 87 gives 115200 baud at 10 MHz
//   SYNC_STAGES    flip-flops in the input synchroniser (>= 2)
//
// Ports
//   clk_10      in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   uart        in   1  raw serial line, idle high
//   byte_data   out  8  last correctly framed byte, held until the next one
//   byte_valid  out  1  one-cycle strobe: byte_data is new this cycle
//   frame_err   out  1  one-cycle strobe: stop bit sampled low, byte dropped
//   busy        out  1  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int CLKS_PER_BAUD = 87,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk_10,
  input  logic       rst,
  input  logic       uart,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BAUD / 2;
  localparam int TW   = $clog2(CLKS_PER_BAUD);

  // The timer is aligned so that it reads LAST on the cycle after every bit
  // centre, which is the cycle where the vote is decided. It then reloads to
  // zero, and the next decision lands exactly one baud later.
  // START_LOAD is the value placed in the timer on the first START cycle
  // (t = 1). This makes the start-bit decision fall at t = HALF + 1.
  localparam logic [TW-1:0] LAST       = TW'(CLKS_PER_BAUD - 1);
  localparam logic [TW-1:0] START_LOAD = TW'(CLKS_PER_BAUD - 1 - HALF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  // Synchroniser, sample history and receiver state
  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;
  state_e                 state_q;
  logic [TW-1:0]          timer_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             byte_data_q;
  logic                   byte_valid_q;
  logic                   frame_err_q;

  // Combinational helpers
  logic s;
  logic at_decide;
  logic vote;

  // Input synchroniser. The flops reset to the idle level (high). A reset
  // therefore cannot manufacture a start bit on release.
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Two-deep history of the synchronised line. When the timer reads LAST,
  // hist_q[0] holds s from the bit centre and hist_q[1] holds s from one cycle
  // before the centre. The current s is the sample one cycle after the centre.
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], s};
    end
  end

  // 2-of-3 majority vote. A single-cycle glitch on any one sample is outvoted.
  assign at_decide = (timer_q == LAST);
  assign vote      = (hist_q[1] & hist_q[0]) |
                     (hist_q[1] & s)         |
                     (hist_q[0] & s);

  // Receiver state machine with registered outputs.
  // The strobes default low every cycle, so any strobe lasts exactly one cycle.
  // The timer advances only inside a frame and wraps only through its reload
  // at a decision point.
  // On a good stop bit the machine returns to IDLE while the stop bit is still
  // on the line, so a start bit that follows with no gap is caught. On a bad
  // stop bit it parks in WAIT_HIGH. This stops a line held low from being
  // taken as a string of new start bits.
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_HIGH;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!s) begin
            state_q <= START;
            timer_q <= START_LOAD;
          end
        end

        START: begin
          if (at_decide) begin
            timer_q <= '0;
            if (vote) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        DATA: begin
          if (at_decide) begin
            timer_q   <= '0;
            // Bits arrive LSB first. After eight right-shifts, bit 0 of the
            // byte sits in shift_q[0].
            shift_q   <= {vote, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        STOP: begin
          if (at_decide) begin
            timer_q <= '0;
            if (vote) begin
              byte_data_q  <= shift_q;
              byte_valid_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= WAIT_HIGH;
        end
      endcase
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frontend
//
// Directed bench for uart_rx_frontend at 87 clocks per baud with a two-stage
// synchroniser. Line changes are driven one time unit after a rising edge.
// A monitor on the falling edge records every strobe, the cycle it appeared in
// and the byte it carried.
// -----------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int N = 87;

  logic       clk_10;
  logic       rst;
  logic       uart;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         validCount = 0;
  int         errCount   = 0;
  int         bothCount  = 0;
  int         validCycQ[$];
  logic [7:0] validDataQ[$];
  int         startCyc;

  uart_rx_frontend #(
    .CLKS_PER_BAUD(N),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_10    (clk_10),
    .rst       (rst),
    .uart      (uart),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // 10 MHz clock
  initial clk_10 = 1'b0;
  always #5 clk_10 = ~clk_10;

  // Cycle counter: after rising edge k, cyc reads k
  always @(posedge clk_10) cyc <= cyc + 1;

  // Strobe monitor sampled mid-cycle
  always @(negedge clk_10) begin
    if (byte_valid === 1'b1) begin
      validCount++;
      validCycQ.push_back(cyc);
      validDataQ.push_back(byte_data);
    end
    if (frame_err === 1'b1) errCount++;
    if (byte_valid === 1'b1 && frame_err === 1'b1) bothCount++;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold the line at v for the given number of rising edges. The task ends one
  // time unit after the last of those edges.
  task automatic holdLine(input logic v, input int cycles);
    uart = v;
    repeat (cycles) begin
      @(posedge clk_10);
      #1;
    end
  endtask

  // One 8N1 frame. glitchBit >= 0 inverts that data bit for one cycle on its
  // centre. stopLowBauds > 0 holds the stop bit low for that many bauds.
  task automatic applyStimulus(input logic [7:0] data, input int glitchBit,
                               input int stopLowBauds);
    holdLine(1'b0, N);
    for (int i = 0; i < 8; i++) begin
      if (i == glitchBit) begin
        holdLine(data[i], N / 2);
        holdLine(~data[i], 1);
        holdLine(data[i], N - N / 2 - 1);
      end else begin
        holdLine(data[i], N);
      end
    end
    if (stopLowBauds > 0) holdLine(1'b0, stopLowBauds * N);
    else holdLine(1'b1, N);
  endtask

  initial begin
    uart = 1'b1;
    rst  = 1'b0;
    #1 rst = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_byte_data", 32'(byte_data), 32'h00);
    checkOutput("rst_byte_valid", 32'(byte_valid), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);
    repeat (3) @(posedge clk_10);
    #1 rst = 1'b0;
    holdLine(1'b1, 5);
    checkOutput("idle_after_reset_busy", 32'(busy), 32'h0);

    // Frame 0xA5. The strobe should come 828 cycles after s falls, plus the
    // two synchroniser cycles.
    $display("[TB] frame A5 latency");
    startCyc = cyc;
    applyStimulus(8'hA5, -1, 0);
    holdLine(1'b1, 20);
    checkOutput("a5_valid_count", 32'(validCount), 32'd1);
    checkOutput("a5_byte_data", 32'(byte_data), 32'hA5);
    checkOutput("a5_latency", 32'(validCycQ[$] - startCyc), 32'd830);
    checkOutput("a5_err_count", 32'(errCount), 32'd0);
    checkOutput("a5_busy_after", 32'(busy), 32'h0);

    // A 20-cycle low pulse is a false start. busy drops at the start of
    // cycle t = 45.
    $display("[TB] false start");
    holdLine(1'b0, 20);
    checkOutput("fs_busy_during", 32'(busy), 32'h1);
    holdLine(1'b1, 26);
    checkOutput("fs_busy_at_t44", 32'(busy), 32'h1);
    holdLine(1'b1, 1);
    checkOutput("fs_busy_at_t45", 32'(busy), 32'h0);
    holdLine(1'b1, 20);
    checkOutput("fs_no_valid", 32'(validCount), 32'd1);
    checkOutput("fs_no_err", 32'(errCount), 32'd0);
    applyStimulus(8'h5A, -1, 0);
    holdLine(1'b1, 20);
    checkOutput("5a_valid_count", 32'(validCount), 32'd2);
    checkOutput("5a_byte_data", 32'(byte_data), 32'h5A);

    // Frame 0x0F with a one-cycle glitch on the centre of bit 3
    $display("[TB] glitch rejection");
    applyStimulus(8'h0F, 3, 0);
    holdLine(1'b1, 20);
    checkOutput("glitch_valid_count", 32'(validCount), 32'd3);
    checkOutput("glitch_byte_data", 32'(byte_data), 32'h0F);

    // Frame 0x00 whose stop bit stays low for three bauds
    $display("[TB] framing error");
    applyStimulus(8'h00, -1, 3);
    checkOutput("fe_err_count", 32'(errCount), 32'd1);
    checkOutput("fe_no_valid", 32'(validCount), 32'd3);
    checkOutput("fe_busy_low_line", 32'(busy), 32'h1);
    checkOutput("fe_byte_data_held", 32'(byte_data), 32'h0F);
    holdLine(1'b1, N);
    checkOutput("fe_busy_line_high", 32'(busy), 32'h0);
    applyStimulus(8'h3C, -1, 0);
    holdLine(1'b1, 20);
    checkOutput("3c_valid_count", 32'(validCount), 32'd4);
    checkOutput("3c_byte_data", 32'(byte_data), 32'h3C);
    checkOutput("3c_err_count", 32'(errCount), 32'd1);

    // Back-to-back frames with no idle gap: strobes exactly one frame apart
    $display("[TB] back-to-back frames");
    applyStimulus(8'h01, -1, 0);
    applyStimulus(8'hFF, -1, 0);
    holdLine(1'b1, 20);
    checkOutput("b2b_valid_count", 32'(validCount), 32'd6);
    checkOutput("b2b_first_data", 32'(validDataQ[$-1]), 32'h01);
    checkOutput("b2b_second_data", 32'(validDataQ[$]), 32'hFF);
    checkOutput("b2b_spacing", 32'(validCycQ[$] - validCycQ[$-1]), 32'd870);

    // Reset pulsed during data bit 4 of 0x77 and held until the stop bit
    $display("[TB] mid-frame reset");
    holdLine(1'b0, N);
    holdLine(1'b1, N);
    holdLine(1'b1, N);
    holdLine(1'b1, N);
    holdLine(1'b0, N);
    holdLine(1'b1, 20);
    rst = 1'b1;
    #1;
    checkOutput("mr_byte_data", 32'(byte_data), 32'h00);
    checkOutput("mr_byte_valid", 32'(byte_valid), 32'h0);
    checkOutput("mr_frame_err", 32'(frame_err), 32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h1);
    holdLine(1'b1, N - 20);
    holdLine(1'b1, N);
    holdLine(1'b1, N);
    holdLine(1'b0, N);
    holdLine(1'b1, 10);
    checkOutput("mr_busy_in_reset", 32'(busy), 32'h1);
    rst = 1'b0;
    holdLine(1'b1, N + 20);
    checkOutput("mr_no_valid", 32'(validCount), 32'd6);
    checkOutput("mr_no_err", 32'(errCount), 32'd1);
    checkOutput("mr_data_still_reset", 32'(byte_data), 32'h00);
    checkOutput("mr_idle", 32'(busy), 32'h0);
    applyStimulus(8'hC3, -1, 0);
    holdLine(1'b1, 20);
    checkOutput("c3_valid_count", 32'(validCount), 32'd7);
    checkOutput("c3_byte_data", 32'(byte_data), 32'hC3);

    checkOutput("never_both_strobes", 32'(bothCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
